// File: rtl/rgb_pwm_breathe.sv
// Multi-LED RGB breathing controller: free-running PWM, per-colour rise/fall
// brightness ramp with capped level, plus static-colour, freeze and off modes.
module rgb_pwm_breathe #(
    parameter int NUM_LEDS   = 2,
    parameter int PWM_WIDTH  = 8,
    parameter int STEP_DIV   = 390625,
    parameter int BRIGHT_CAP = 128
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               mode,
    input  logic [3*PWM_WIDTH-1:0]   static_rgb,
    output logic [3*NUM_LEDS-1:0]    dout,
    output logic [2:0]               color_sel,
    output logic                     phase_fall,
    output logic                     cycle_done
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'b00,
        MODE_BREATHE = 2'b01,
        MODE_STATIC  = 2'b10,
        MODE_FREEZE  = 2'b11
    } mode_e;

    typedef enum logic {
        RISE = 1'b0,
        FALL = 1'b1
    } state_e;

    localparam int CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]     CNT_MAX = CNT_W'(STEP_DIV - 1);
    localparam logic [PWM_WIDTH-1:0] CAP     = PWM_WIDTH'(BRIGHT_CAP);

    function automatic logic [PWM_WIDTH-1:0] sat_cap(input logic [PWM_WIDTH-1:0] v);
        return (v > CAP) ? CAP : v;
    endfunction

    mode_e                  mode_s;
    mode_e                  prev_mode_q, prev_mode_d;
    state_e                 state_q, state_d;
    logic [PWM_WIDTH-1:0]   pwm_q, pwm_d;
    logic [PWM_WIDTH-1:0]   duty_q, duty_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [2:0]             color_q, color_d;
    logic [3*NUM_LEDS-1:0]  dout_q, dout_d;
    logic                   done_q, done_d;
    logic                   restart, tick;
    logic [PWM_WIDTH-1:0]   bright, e_breathe;
    logic [PWM_WIDTH-1:0]   level [3];

    assign mode_s = mode_e'(mode);

    // Ramp control: restart only when arriving from OFF/STATIC; FREEZE resumes in place.
    always_comb begin
        pwm_d       = pwm_q + 1'b1;
        prev_mode_d = mode_s;
        cnt_d       = cnt_q;
        duty_d      = duty_q;
        state_d     = state_q;
        color_d     = color_q;
        done_d      = 1'b0;
        restart     = (mode_s == MODE_BREATHE) && (prev_mode_q != MODE_BREATHE)
                      && (prev_mode_q != MODE_FREEZE);
        tick        = (cnt_q == CNT_MAX);
        if (mode_s == MODE_BREATHE) begin
            if (restart) begin
                cnt_d   = '0;
                duty_d  = '0;
                state_d = RISE;
                color_d = 3'b001;
            end else if (tick) begin
                cnt_d  = '0;
                duty_d = duty_q + 1'b1;
                if (duty_q == '1) begin
                    if (state_q == RISE) begin
                        state_d = FALL;
                    end else begin
                        state_d = RISE;
                        color_d = {color_q[1:0], color_q[2]};
                        done_d  = color_q[2];
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bright    = (state_q == FALL) ? ~duty_q : duty_q;
        e_breathe = sat_cap(bright);
        for (int c = 0; c < 3; c++) begin
            level[c] = '0;
            case (mode_s)
                MODE_BREATHE, MODE_FREEZE: level[c] = color_q[c] ? e_breathe : '0;
                MODE_STATIC:               level[c] = sat_cap(static_rgb[c*PWM_WIDTH +: PWM_WIDTH]);
                default:                   level[c] = '0;
            endcase
        end
        dout_d = '0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            for (int c = 0; c < 3; c++) begin
                dout_d[3*i+c] = (level[c] > pwm_q);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_q       <= '0;
            cnt_q       <= '0;
            duty_q      <= '0;
            state_q     <= RISE;
            color_q     <= 3'b001;
            dout_q      <= '0;
            done_q      <= 1'b0;
            prev_mode_q <= MODE_OFF;
        end else begin
            pwm_q       <= pwm_d;
            cnt_q       <= cnt_d;
            duty_q      <= duty_d;
            state_q     <= state_d;
            color_q     <= color_d;
            dout_q      <= dout_d;
            done_q      <= done_d;
            prev_mode_q <= prev_mode_d;
        end
    end

    assign dout       = dout_q;
    assign color_sel  = color_q;
    assign phase_fall = (state_q == FALL);
    assign cycle_done = done_q;

endmodule

// File: tb/tb_rgb_pwm_breathe.sv
// Directed bench for rgb_pwm_breathe: ramp timing, capping, static, freeze,
// off, async reset, plus a STEP_DIV=1 instance.
module tb_rgb_pwm_breathe;

    localparam int NL = 2;
    localparam int PW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst, rst1;
    logic [1:0]        mode, mode1;
    logic [3*PW-1:0]   static_rgb;
    logic [3*NL-1:0]   dout, dout1;
    logic [2:0]        color_sel, color_sel1;
    logic              phase_fall, phase_fall1;
    logic              cycle_done, cycle_done1;

    int n_assert = 0;
    int n_fail   = 0;
    int hi [6];

    rgb_pwm_breathe #(.NUM_LEDS(NL), .PWM_WIDTH(PW), .STEP_DIV(2), .BRIGHT_CAP(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .static_rgb(static_rgb),
        .dout(dout), .color_sel(color_sel), .phase_fall(phase_fall), .cycle_done(cycle_done)
    );

    rgb_pwm_breathe #(.NUM_LEDS(NL), .PWM_WIDTH(PW), .STEP_DIV(1), .BRIGHT_CAP(8)) dut1 (
        .clk(clk), .rst(rst1), .mode(mode1), .static_rgb(static_rgb),
        .dout(dout1), .color_sel(color_sel1), .phase_fall(phase_fall1), .cycle_done(cycle_done1)
    );

    task automatic chk(input string tag, input int act, input int exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Count high cycles of every dout bit over one full 16-cycle PWM window.
    task automatic win();
        step(2);
        for (int b = 0; b < 6; b++) hi[b] = 0;
        for (int k = 0; k < 16; k++) begin
            @(posedge clk);
            #1;
            for (int b = 0; b < 6; b++) hi[b] += int'(dout[b]);
        end
        @(negedge clk);
    endtask

    task automatic chk_win(input string tag, input int r, input int g, input int b);
        win();
        chk({tag, ".r0"}, hi[0], r);
        chk({tag, ".g0"}, hi[1], g);
        chk({tag, ".b0"}, hi[2], b);
        chk({tag, ".r1"}, hi[3], r);
        chk({tag, ".g1"}, hi[4], g);
        chk({tag, ".b1"}, hi[5], b);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int cd_cnt;
        rst = 1'b1; rst1 = 1'b1;
        mode = 2'b01; mode1 = 2'b01;
        static_rgb = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.dout", int'(dout), 0);
        chk("rst.color", int'(color_sel), 1);
        chk("rst.phase", int'(phase_fall), 0);
        chk("rst.done", int'(cycle_done), 0);

        // Full breathing cycle timing from reset.
        rst = 1'b0;
        cd_cnt = 0;
        for (int e = 1; e <= 260; e++) begin
            @(posedge clk);
            #1;
            if (cycle_done) cd_cnt++;
            if (e == 32)  chk("t32.phase", int'(phase_fall), 0);
            if (e == 33)  chk("t33.phase", int'(phase_fall), 1);
            if (e == 64)  chk("t64.color", int'(color_sel), 1);
            if (e == 65)  chk("t65.color", int'(color_sel), 2);
            if (e == 128) chk("t128.color", int'(color_sel), 2);
            if (e == 129) chk("t129.color", int'(color_sel), 4);
            if (e == 192) chk("t192.color", int'(color_sel), 4);
            if (e == 192) chk("t192.done", int'(cycle_done), 0);
            if (e == 193) chk("t193.color", int'(color_sel), 1);
            if (e == 193) chk("t193.done", int'(cycle_done), 1);
            if (e == 194) chk("t194.done", int'(cycle_done), 0);
            if (e == 257) chk("t257.color", int'(color_sel), 2);
        end
        chk("cycle_done.pulses", cd_cnt, 1);

        // Asynchronous reset between clock edges while breathing on G.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("arst.color", int'(color_sel), 1);
        chk("arst.phase", int'(phase_fall), 0);
        chk("arst.dout", int'(dout), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Ramp restarts from 0 on R: duty 3 after 7 cycles.
        step(7);
        mode = 2'b11;
        chk_win("ramp3", 3, 0, 0);

        mode = 2'b01; step(4); mode = 2'b11;
        chk_win("duty5", 5, 0, 0);

        mode = 2'b01; step(4); mode = 2'b11;
        step(100);
        chk_win("freeze7", 7, 0, 0);
        chk("freeze7.color", int'(color_sel), 1);
        chk("freeze7.phase", int'(phase_fall), 0);

        mode = 2'b01; step(10); mode = 2'b11;
        chk_win("duty12cap", 8, 0, 0);

        // Static colour R=3, G=15 (capped to 8), B=0.
        static_rgb = {4'd0, 4'd15, 4'd3};
        mode = 2'b10;
        chk_win("static", 3, 8, 0);
        chk("static.color", int'(color_sel), 1);

        // STATIC -> BREATHE restarts the ramp at 0.
        mode = 2'b01; step(7); mode = 2'b11;
        chk_win("restart", 3, 0, 0);

        mode = 2'b00;
        step(2);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            chk("off.dout", int'(dout), 0);
        end
        @(negedge clk);
        mode = 2'b11;
        chk_win("off_hold", 3, 0, 0);

        // STEP_DIV=1 instance: one duty step per clock.
        rst1 = 1'b0;
        for (int e = 1; e <= 34; e++) begin
            @(posedge clk);
            #1;
            if (e == 16) chk("sd1.t16.phase", int'(phase_fall1), 0);
            if (e == 17) chk("sd1.t17.phase", int'(phase_fall1), 1);
            if (e == 32) chk("sd1.t32.color", int'(color_sel1), 1);
            if (e == 33) chk("sd1.t33.color", int'(color_sel1), 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/rgb_pwm_breathe.md
Name: rgb_pwm_breathe

Overview:
- Parametrised multi-LED RGB breathing controller, the successor to the fixed two-LED R/G/B cycler.
- Drives NUM_LEDS tri-colour LEDs with a free-running PWM.
- Supports runtime modes: off, breathing colour cycle, static colour, and freeze.
- Sits between the top-level mode/colour control and the LED pins; status outputs feed the debug/IO blocks.

Parameters:
- NUM_LEDS, 2, number of RGB LEDs driven identically (>=1).
- PWM_WIDTH, 8, bit width of PWM counter, duty and static levels (2..16); PWM period = 2^PWM_WIDTH clk cycles.
- STEP_DIV, 390625, clk cycles per brightness step (>=1).
- BRIGHT_CAP, 128, maximum effective brightness (<= 2^PWM_WIDTH-1).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- mode  in  2  00 OFF, 01 BREATHE, 10 STATIC, 11 FREEZE
- static_rgb  in  3*PWM_WIDTH  static levels: [W-1:0]=R, [2W-1:W]=G, [3W-1:2W]=B
- dout  out  3*NUM_LEDS  LED drives; dout[3i+0]=R, [3i+1]=G, [3i+2]=B of LED i
- color_sel  out  3  one-hot active breathing colour; bit0=R, bit1=G, bit2=B
- phase_fall  out  1  0 while rising, 1 while falling
- cycle_done  out  1  one-cycle pulse when the B fall completes (full R-G-B cycle done)

Behaviour:
- Reset (async, immediate): pwm=0, step counter=0, duty=0, state RISE, color_sel=3'b001, dout=0, cycle_done=0, phase_fall=0, previous-mode register=OFF.
- pwm: PWM_WIDTH-bit counter; increments every clk in all modes; wraps 2^W-1 -> 0.
- Step counter: runs only in BREATHE. tick = (cnt == STEP_DIV-1); on tick cnt<=0, else cnt+1. Width $clog2(STEP_DIV), minimum 1. With STEP_DIV=1, tick every cycle.
- On tick in BREATHE: duty<=duty+1 (wraps). If duty==2^W-1 at the tick:
  - RISE -> FALL.
  - FALL -> RISE, and color_sel rotates left (001->010->100->001).
  - cycle_done pulses the following cycle when rotating from 100 -> 001.
- Brightness: RISE: b=duty; FALL: b=~duty. Effective e = min(b, BRIGHT_CAP).
- Entering BREATHE from OFF or STATIC (mode change detected via the registered previous mode): in the first BREATHE cycle set duty=0, cnt=0, RISE, color_sel=001. Entering from FREEZE resumes with no reset of duty, state, colour or cnt.
- FREEZE: cnt, duty, state and color_sel hold. PWM keeps running; output uses the held e.
- OFF: dout=0; duty, state and colour hold.
- STATIC: per colour c, e_c = min(static_rgb_c, BRIGHT_CAP); the same level goes to every LED. color_sel and phase_fall hold.
- Output is registered, one-cycle latency: dout[3i+c] <= (e_c > pwm), where e_c = e when color_sel[c] in BREATHE/FREEZE, 0 otherwise. High for e_c cycles of each 2^W window; e=0 gives always low. No glitches between LEDs: all LEDs are identical.
- Mode change takes effect on dout one cycle after mode is sampled.
- phase_fall = (state==FALL), registered with state.

Test Plan:
- Bench params: NUM_LEDS=2, PWM_WIDTH=4, STEP_DIV=2, BRIGHT_CAP=8 unless stated.
- Reset mid-BREATHE: assert rst asynchronously between clk edges -> dout=0, color_sel=001, phase_fall=0 immediately. After release with mode=01, R duty ramps from 0.
- BREATHE timing: mode=01 from reset -> phase_fall rises after 32 cycles; color_sel=010 after 64; 100 after 128; cycle_done pulses once, ~192 cycles after entry; color_sel back to 001.
- Cap/duty: in BREATHE at duty=5 RISE -> dout[0] and dout[3] high 5 of 16 cycles. At duty 12 RISE -> high 8 of 16 (capped). G and B bits stay 0.
- STATIC: static_rgb R=3, G=15, B=0 -> per 16-cycle window R high 3, G high 8, B high 0, on both LEDs identically.
- FREEZE/resume: FREEZE at duty=7 for 100 cycles -> duty and colour unchanged, dout duty stays 7/16. Return to BREATHE -> ramp continues from 7. STATIC->BREATHE restarts at duty=0, colour R.
- OFF and STEP_DIV=1: mode=00 -> dout=0 every cycle. Rerun with STEP_DIV=1 -> duty advances every clk, RISE lasts 16 cycles.
